// File: rtl/dm_pkg.sv
// Shared definitions for the RV32I data memory: access-size codes, FSM states, alignment check.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package dm_pkg;

  // Access size/sign codes, identical to the load/store funct3 field
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_RUN   = 1'b1
  } dm_state_t;

  // True when the access cannot be performed: bad alignment for its size, or an unused code
  function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic mis;
    case (ctrl)
      DM_B, DM_BU: mis = 1'b0;
      DM_H, DM_HU: mis = addr_lo[0];
      DM_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Core-to-data-memory bus: address, store data, size code and the memory's responses.
// Latency: n/a (wiring only).
// Backpressure: Ready low tells the core to stall the PC.
interface data_memory_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        Ready;
  logic        Misaligned;
  logic        StoreErr;

  modport master (
    output Address, DataWr, DMWr, DMCtrl,
    input  DataRd, Ready, Misaligned, StoreErr
  );

  modport slave (
    input  Address, DataWr, DMWr, DMCtrl,
    output DataRd, Ready, Misaligned, StoreErr
  );
endinterface

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
// Latency: combinational, zero cycles.
// Backpressure: none; unknown size codes yield zero.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ctrl,
  output logic [31:0] data_rd
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and half (little-endian) out of the word
  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the access size/sign
  always_comb begin
    data_rd = '0;
    case (ctrl)
      DM_B:  data_rd = {{24{lane_b[7]}}, lane_b};
      DM_BU: data_rd = {24'd0, lane_b};
      DM_H:  data_rd = {{16{lane_h[15]}}, lane_h};
      DM_HU: data_rd = {16'd0, lane_h};
      DM_W:  data_rd = word;
      default: data_rd = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory with self-clearing after reset and a sticky store-error flag.
// Latency: loads combinational (0 cycles); stores commit on the rising edge.
// Backpressure: Ready held low for DEPTH cycles after reset while every word is zeroed.
module data_memory
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic           clk,
  input  logic           rst,
  data_memory_if.slave   bus
);

  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];

  dm_state_t     state;
  logic [AW-1:0] ptr;
  logic          ready_q;
  logic          store_err_q;

  logic [AW-1:0] idx;
  logic          mis;
  logic          run;
  logic          st_ok;
  logic          st_rej;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_dat;

  // Upper address bits are deliberately dropped: the memory aliases every 4*DEPTH bytes
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address[31:AW+2];

  assign idx     = bus.Address[AW+1:2];
  assign mis     = dm_misaligned(bus.DMCtrl, bus.Address[1:0]);
  assign run     = (state == DM_RUN);
  assign st_ok   = run & bus.DMWr & ~mis;
  assign st_rej  = run & bus.DMWr & mis;
  assign rd_word = mem[idx];

  dm_load_ext u_load_ext (
    .word    (rd_word),
    .addr_lo (bus.Address[1:0]),
    .ctrl    (bus.DMCtrl),
    .data_rd (ext_data)
  );

  assign bus.DataRd     = (ready_q && !mis) ? ext_data : 32'd0;
  assign bus.Misaligned = mis;
  assign bus.Ready      = ready_q;
  assign bus.StoreErr   = store_err_q;

  // Single write port: the clear sequence owns it in CLEAR, accepted stores own it in RUN
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = idx;
    wr_be  = 4'b0000;
    wr_dat = bus.DataWr;
    if (!rst) begin
      if (!run) begin
        wr_en  = 1'b1;
        wr_idx = ptr;
        wr_be  = 4'b1111;
        wr_dat = 32'd0;
      end else if (st_ok) begin
        wr_en = 1'b1;
        case (bus.DMCtrl)
          DM_B, DM_BU: begin
            wr_be  = 4'b0001 << bus.Address[1:0];
            wr_dat = {4{bus.DataWr[7:0]}};
          end
          DM_H, DM_HU: begin
            wr_be  = bus.Address[1] ? 4'b1100 : 4'b0011;
            wr_dat = {2{bus.DataWr[15:0]}};
          end
          default: begin
            wr_be  = 4'b1111;
            wr_dat = bus.DataWr;
          end
        endcase
      end
    end
  end

  // Byte-lane write into the storage array; untouched lanes keep their contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  // Clear/run sequencer with registered Ready and sticky store-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DM_CLEAR;
      ptr         <= '0;
      ready_q     <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      case (state)
        DM_CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == LAST) begin
            state   <= DM_RUN;
            ready_q <= 1'b1;
          end
        end
        DM_RUN: begin
          if (st_rej) store_err_q <= 1'b1;
        end
        default: begin
          state   <= DM_CLEAR;
          ptr     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory for the single-cycle RV32I core. It is driven by the control unit's `DMWr`/`DMCtrl` outputs, the ALU result (address) and register-unit `rs2` (store data). Its load data feeds the `RUDataWrSrc` write-back mux. After reset it runs a self-clearing sequence, during which it holds `Ready` low so the top level can freeze the PC. It also keeps a sticky error flag for rejected stores.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two, at least 4.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `Address`  input  32  byte address (ALU result).
- `DataWr`  input  32  store data (rs2).
- `DMWr`  input  1  store enable.
- `DMCtrl`  input  3  access size/sign, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `DataRd`  output  32  load data, aligned and extended.
- `Ready`  output  1  memory usable; 0 while clearing.
- `Misaligned`  output  1  combinational: current access is misaligned or `DMCtrl` is invalid.
- `StoreErr`  output  1  sticky: a store was rejected since reset.

## Operation
- Word index = `Address[AW+1:2]`, with AW = clog2(`DEPTH`).
  - `Address[31:AW+2]` is ignored, so addresses alias modulo 4·`DEPTH` bytes.
- Byte order is little-endian. The byte lane is `Address[1:0]`; the half lane is `Address[1]`.
- Misaligned is asserted in any of these cases:
  - H/HU with `Address[0]`=1.
  - W with `Address[1:0]`≠00.
  - `DMCtrl` ∈ {011, 110, 111}.
- Store rules (only when `Ready`=1 and `DMWr`=1 and `Misaligned`=0):
  - B writes `DataWr[7:0]` to the addressed byte.
  - H writes `DataWr[15:0]` to the addressed half.
  - W writes the full word.
  - Untouched bytes are preserved.
  - BU/HU with `DMWr`=1 are treated as B/H stores.
- Rejected store: `DMWr`=1, `Ready`=1 and `Misaligned`=1. Memory is unchanged and `StoreErr` is set on that edge. `StoreErr` clears only on `rst`.
- Loads:
  - B/H are sign-extended; BU/HU are zero-extended; W returns the word.
  - `DataRd`=0 when `Misaligned`=1 or `Ready`=0.
- FSM states:
  - CLEAR: writes 0 to word `ptr` each cycle and increments `ptr`. When `ptr`=`DEPTH`-1 is written, the next state is RUN.
  - RUN: normal access. Stays in RUN until `rst`.
- `DMWr` is ignored in CLEAR, and does not set `StoreErr` there.

## Timing
- Reset values:
  - state=CLEAR, `ptr`=0.
  - `Ready`=0, `StoreErr`=0, `DataRd`=0.
  - `Misaligned` follows its inputs.
- Clear takes exactly `DEPTH` cycles after the reset edge. `Ready` rises on the edge that writes the last word plus one, i.e. it is high in cycle `DEPTH` after `rst` deasserts.
- Asserting `rst` mid-clear or mid-run restarts CLEAR from `ptr`=0 on that edge.
- Loads are combinational: zero-cycle latency from `Address`/`DMCtrl`, as the single-cycle datapath requires.
- Stores commit on the rising edge.
- Read and write to the same word in the same cycle: `DataRd` shows the old value. The new value is visible after the edge.
- `Ready`, `state`, `ptr` and `StoreErr` are registered outputs; there are no combinational paths from `DMWr` to them.

## Structure
- Package `dm_pkg` holds:
  - `DMCtrl` localparams: `DM_B`, `DM_H`, `DM_W`, `DM_BU`, `DM_HU`.
  - State enum `dm_state_t` {`DM_CLEAR`, `DM_RUN`}.
  - A function `dm_misaligned(ctrl, addr_lo)`.
- Sub-module `dm_load_ext`: purely combinational lane select plus sign/zero extension (`word`, `Address[1:0]`, `DMCtrl` → `DataRd`). It is reused by any future load/store unit.
- Top-level `data_memory` holds the storage array, the FSM/`ptr`, the byte-enable write logic and `StoreErr`.

## Test plan
- Reset clear with `DEPTH`=16: pulse `rst`, then hold `DMWr`=1 throughout → `Ready`=0 for 16 cycles and 1 after. All words read 0, and `StoreErr` stays 0.
- Store/load sizes: SW 0x8badf00d @0x8, then LB @0x8 → 0x0000000d. LB @0xB → 0xffffff8b. LBU @0xB → 0x0000008b. LH @0xA → 0xffff8bad. LHU @0x8 → 0x0000f00d.
- Partial store: SW 0x11223344 @0x4, SB 0xAA @0x5, SH 0xBEEF @0x6 → LW @0x4 = 0xBEEFAA44.
- Misalignment: SW 0xFFFFFFFF @0x2 → `Misaligned`=1, LW @0x0 unchanged, `StoreErr`=1 and it stays 1 through later valid stores until `rst`. LH @0x1 → `DataRd`=0. `DMCtrl`=011 → `Misaligned`=1.
- Aliasing and read-during-write with `DEPTH`=16: SW 0x5 @0x40 → LW @0x0 = 0x5. In the store cycle, `DataRd` shows the old value; in the next cycle it shows 0x5.
- Reset mid-operation: assert `rst` at cycle 5 of CLEAR → `Ready` rises exactly `DEPTH` cycles after the second reset. Assert `rst` in RUN after data was written → memory reads 0 and `StoreErr` reads 0.
